// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package div_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 2N, the number of restoring steps per operation.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and conditionally subtract.
module div_step
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] partial_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] partial_o,
    output logic         qbit_o
);

    logic [N:0] trial;

    // The extra top bit lets the trial value exceed any N-bit divisor without overflow.
    assign trial     = {partial_i, bit_i};
    assign qbit_o    = (trial >= {1'b0, divisor_i});
    assign partial_o = N'(qbit_o ? (trial - {1'b0, divisor_i}) : trial);

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CNT_W = cnt_width(N);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     p_q, p_d;
    logic [2*N-1:0]   shreg_q, shreg_d;
    logic [N-1:0]     divisor_q, divisor_d;
    logic [2*N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]     remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [N-1:0]     step_p;
    logic             step_qbit;

    div_step #(.N(N)) u_step (
        .partial_i (p_q),
        .bit_i     (shreg_q[2*N-1]),
        .divisor_i (divisor_q),
        .partial_o (step_p),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        shreg_d     = shreg_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = dividend;
                    divisor_d = divisor;
                    p_d       = '0;
                    cnt_d     = CNT_W'(2 * N);
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend[N-1:0];
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d     = step_p;
                shreg_d = {shreg_q[2*N-2:0], step_qbit};
                cnt_d   = cnt_q - 1'b1;
                // Publish results only on the final step so outputs stay stable mid-run.
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = {shreg_q[2*N-2:0], step_qbit};
                    remainder_d = step_p;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            shreg_q     <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            shreg_q     <= shreg_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
